pipe_control_unit: RTL and testbench

//  Successor to the single-cycle opcode decoder. It decodes the ID-stage opcode into the 8-bit control word
//  and carries that word through the ID/EX, EX/MEM and MEM/WB registers. Outputs are per-stage controls.
//  It also detects load-use and branch-operand hazards, inserts bubbles, resolves branch/jump in ID,

---
 rtl/pipe_control_unit.sv | 124 ++++++++++++
 tb/tb_pipe_control_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes the ID opcode into an 8-bit control word, carries it through
// ID/EX, EX/MEM and MEM/WB, detects load-use and branch-operand hazards and resolves branch/jump in ID.
module pipe_control_unit #(
  parameter int OP_W   = 6,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16,
  parameter int BR_FWD = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [RA_W-1:0]  rs_i,
  input  logic [RA_W-1:0]  rt_i,
  input  logic [RA_W-1:0]  rd_i,
  input  logic             branch_eq_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic             branch_o,
  output logic             jump_o,
  output logic             illegal_o,
  output logic             ex_alusrc_o,
  output logic [1:0]       ex_aluop_o,
  output logic             ex_regdst_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             wb_regwrite_o,
  output logic             wb_memtoreg_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'('h08);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_J    = OP_W'('h02);

  // Word layout: [0] ALUSrc, [2:1] ALUOp, [3] RegDst, [4] MemRead, [5] MemWrite, [6] RegWrite, [7] MemtoReg
  logic [7:0]      id_word;
  logic            reads_rs;
  logic            reads_rt;
  logic            is_beq;
  logic            is_j;
  logic            unknown_op;
  logic [RA_W-1:0] id_dst;

  logic [7:0]      idex_word;
  logic [RA_W-1:0] idex_dst;
  logic [3:0]      exmem_word;
  logic [RA_W-1:0] exmem_dst;
  logic [1:0]      memwb_word;
  logic [CNT_W-1:0] stall_cnt;

  logic load_use;
  logic idex_br_hit;
  logic exmem_br_hit;
  logic branch_haz;
  logic stall;

  always_comb begin
    id_word    = 8'h00;
    reads_rs   = 1'b0;
    reads_rt   = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    unknown_op = 1'b0;
    case (op_i)
      OP_R:    begin id_word = 8'h4E; reads_rs = 1'b1; reads_rt = 1'b1; end
      OP_ADDI: begin id_word = 8'h41; reads_rs = 1'b1; end
      OP_LW:   begin id_word = 8'hD1; reads_rs = 1'b1; end
      OP_SW:   begin id_word = 8'h21; reads_rs = 1'b1; reads_rt = 1'b1; end
      OP_BEQ:  begin id_word = 8'h02; reads_rs = 1'b1; reads_rt = 1'b1; is_beq = 1'b1; end
      OP_J:    is_j = 1'b1;
      default: unknown_op = 1'b1;
    endcase
  end

  assign id_dst = id_word[3] ? rd_i : rt_i;

  assign load_use = idex_word[4] && (idex_dst != '0) &&
                    ((reads_rs && idex_dst == rs_i) || (reads_rt && idex_dst == rt_i));

  assign idex_br_hit  = idex_word[6] && (idex_dst != '0) &&
                        (idex_dst == rs_i || idex_dst == rt_i);
  // With forwarding, only a load still in MEM cannot supply the comparator in time.
  assign exmem_br_hit = ((BR_FWD == 0) || exmem_word[0]) && exmem_word[2] && (exmem_dst != '0) &&
                        (exmem_dst == rs_i || exmem_dst == rt_i);
  assign branch_haz   = is_beq && (idex_br_hit || exmem_br_hit);

  assign stall = load_use | branch_haz;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_word  <= '0;
      idex_dst   <= '0;
      exmem_word <= '0;
      exmem_dst  <= '0;
      memwb_word <= '0;
      stall_cnt  <= '0;
    end else begin
      idex_word  <= stall ? 8'h00 : id_word;
      idex_dst   <= stall ? '0 : id_dst;
      exmem_word <= idex_word[7:4];
      exmem_dst  <= idex_dst;
      memwb_word <= exmem_word[3:2];
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_o       = stall;
  assign branch_o      = !stall && is_beq && branch_eq_i;
  assign jump_o        = !stall && is_j;
  assign flush_o       = branch_o | jump_o;
  assign illegal_o     = unknown_op;
  assign ex_alusrc_o   = idex_word[0];
  assign ex_aluop_o    = idex_word[2:1];
  assign ex_regdst_o   = idex_word[3];
  assign mem_read_o    = exmem_word[0];
  assign mem_write_o   = exmem_word[1];
  assign wb_regwrite_o = memwb_word[0];
  assign wb_memtoreg_o = memwb_word[1];
  assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: two instances (no forwarding / 16-bit counter, forwarding / 2-bit counter)
// share one instruction stream and are checked against an instruction-level pipeline model.
module tb_pipe_control_unit;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam int W = 29;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] op_i = '0;
  logic [4:0] rs_i = '0, rt_i = '0, rd_i = '0;
  logic       branch_eq_i = 1'b0;

  logic a_stall, a_flush, a_branch, a_jump, a_illegal, a_alusrc, a_regdst;
  logic a_mread, a_mwrite, a_wbrw, a_mtr;
  logic [1:0]  a_aluop;
  logic [15:0] a_cnt;
  logic b_stall, b_flush, b_branch, b_jump, b_illegal, b_alusrc, b_regdst;
  logic b_mread, b_mwrite, b_wbrw, b_mtr;
  logic [1:0] b_aluop;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  pipe_control_unit #(.CNT_W(16), .BR_FWD(0)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .branch_eq_i(branch_eq_i), .stall_o(a_stall), .flush_o(a_flush), .branch_o(a_branch),
    .jump_o(a_jump), .illegal_o(a_illegal), .ex_alusrc_o(a_alusrc), .ex_aluop_o(a_aluop),
    .ex_regdst_o(a_regdst), .mem_read_o(a_mread), .mem_write_o(a_mwrite),
    .wb_regwrite_o(a_wbrw), .wb_memtoreg_o(a_mtr), .stall_cnt_o(a_cnt)
  );

  pipe_control_unit #(.CNT_W(2), .BR_FWD(1)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .branch_eq_i(branch_eq_i), .stall_o(b_stall), .flush_o(b_flush), .branch_o(b_branch),
    .jump_o(b_jump), .illegal_o(b_illegal), .ex_alusrc_o(b_alusrc), .ex_aluop_o(b_aluop),
    .ex_regdst_o(b_regdst), .mem_read_o(b_mread), .mem_write_o(b_mwrite),
    .wb_regwrite_o(b_wbrw), .wb_memtoreg_o(b_mtr), .stall_cnt_o(b_cnt)
  );

  logic [W-1:0] act_a, act_b;
  assign act_a = {a_stall, a_flush, a_branch, a_jump, a_illegal, a_alusrc, a_aluop, a_regdst,
                  a_mread, a_mwrite, a_wbrw, a_mtr, a_cnt};
  assign act_b = {b_stall, b_flush, b_branch, b_jump, b_illegal, b_alusrc, b_aluop, b_regdst,
                  b_mread, b_mwrite, b_wbrw, b_mtr, 14'd0, b_cnt};

  // One in-flight instruction per stage; v=0 is a bubble.
  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] dst;
  } stage_t;

  stage_t m_ex[2], m_mem[2], m_wb[2];
  int     m_cnt[2];
  int     checks = 0;
  int     errors = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  function automatic logic writes_reg(stage_t s);
    return s.v && (s.op == OP_R || s.op == OP_ADDI || s.op == OP_LW);
  endfunction

  function automatic logic is_load(stage_t s);
    return s.v && s.op == OP_LW;
  endfunction

  function automatic logic reads_reg(logic [5:0] op, logic [4:0] r, logic [4:0] rs, logic [4:0] rt);
    case (op)
      OP_R, OP_SW, OP_BEQ: return (r == rs) || (r == rt);
      OP_ADDI, OP_LW:      return r == rs;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic known_op(logic [5:0] op);
    return op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one ID-stage instruction after the clock edge, then records what each DUT must show
  // this cycle and advances the model as of the next edge.
  task automatic step(input logic r, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic eq);
    @(posedge clk);
    #1;
    rst_i = r; op_i = op; rs_i = rs; rt_i = rt; rd_i = rd; branch_eq_i = eq;
    for (int d = 0; d < 2; d++) begin
      logic lu, bh, st, br, jp, mem_blocks;
      logic [W-1:0] e;
      logic [1:0] aluop;
      if (!r) begin
        m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0; m_cnt[d] = 0;
      end
      lu = is_load(m_ex[d]) && m_ex[d].dst != 0 && reads_reg(op, m_ex[d].dst, rs, rt);
      mem_blocks = (d == 0 || is_load(m_mem[d])) && writes_reg(m_mem[d]) && m_mem[d].dst != 0 &&
                   (m_mem[d].dst == rs || m_mem[d].dst == rt);
      bh = (op == OP_BEQ) && ((writes_reg(m_ex[d]) && m_ex[d].dst != 0 &&
                               (m_ex[d].dst == rs || m_ex[d].dst == rt)) || mem_blocks);
      st = lu | bh;
      br = !st && op == OP_BEQ && eq;
      jp = !st && op == OP_J;
      aluop = !m_ex[d].v ? 2'd0 : (m_ex[d].op == OP_R) ? 2'd3 : (m_ex[d].op == OP_BEQ) ? 2'd1 : 2'd0;
      e = {st, br | jp, br, jp, !known_op(op),
           m_ex[d].v && (m_ex[d].op == OP_ADDI || m_ex[d].op == OP_LW || m_ex[d].op == OP_SW),
           aluop, m_ex[d].v && m_ex[d].op == OP_R,
           is_load(m_mem[d]), m_mem[d].v && m_mem[d].op == OP_SW,
           writes_reg(m_wb[d]), is_load(m_wb[d]), 16'(m_cnt[d])};
      if (d == 0) exp_a_q.push_back(e);
      else        exp_b_q.push_back(e);
      if (r) begin
        m_wb[d]  = m_mem[d];
        m_mem[d] = m_ex[d];
        m_ex[d]  = st ? stage_t'('0) : stage_t'({1'b1, op, (op == OP_R) ? rd : rt});
        if (st && m_cnt[d] < ((d == 0) ? 65535 : 3)) m_cnt[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_a_q.size() > 0) check("dut_a outputs", act_a, exp_a_q.pop_front());
    if (exp_b_q.size() > 0) check("dut_b outputs", act_b, exp_b_q.pop_front());
  end

  task automatic settle_nops(input int n);
    repeat (n) step(1'b1, OP_J, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    int sa, sb;
    logic [5:0] op;
    step(1'b0, OP_J, 0, 0, 0, 0);
    step(1'b0, OP_LW, 1, 2, 3, 0);
    step(1'b1, OP_J, 0, 0, 0, 0);

    // lw $2 ; add $3,$2,$4
    step(1'b1, OP_LW, 0, 2, 0, 0);
    step(1'b1, OP_R, 2, 4, 3, 0);
    #2; check("load_use stall a", W'(a_stall), W'(1)); check("load_use stall b", W'(b_stall), W'(1));
    step(1'b1, OP_R, 2, 4, 3, 0);
    #2; check("load_use released", W'(a_stall), W'(0));
    settle_nops(1);
    #2; check("add late in ex", W'(a_aluop), W'(3)); check("stall count one", W'(a_cnt), W'(1));

    // lw $5 ; beq $5,$0 held in ID
    settle_nops(3);
    step(1'b1, OP_LW, 0, 5, 0, 0);
    sa = 0; sb = 0;
    repeat (3) begin step(1'b1, OP_BEQ, 5, 0, 0, 0); #2; sa += a_stall; sb += b_stall; end
    check("lw_beq stalls nofwd", W'(sa), W'(2));
    check("lw_beq stalls fwd", W'(sb), W'(2));

    // add $5 ; beq $5,$0 held in ID
    settle_nops(3);
    step(1'b1, OP_R, 0, 0, 5, 0);
    sa = 0; sb = 0;
    repeat (3) begin step(1'b1, OP_BEQ, 5, 0, 0, 0); #2; sa += a_stall; sb += b_stall; end
    check("add_beq stalls nofwd", W'(sa), W'(2));
    check("add_beq stalls fwd", W'(sb), W'(1));

    // Redirects without hazards
    settle_nops(3);
    step(1'b1, OP_BEQ, 1, 2, 0, 1);
    #2; check("beq taken branch", W'(a_branch), W'(1)); check("beq taken flush", W'(a_flush), W'(1));
    step(1'b1, OP_BEQ, 1, 2, 0, 0);
    #2; check("beq not taken", W'({a_branch, a_flush}), W'(0));
    step(1'b1, OP_J, 0, 0, 0, 0);
    #2; check("jump", W'({a_jump, a_flush}), W'(3));
    step(1'b1, 6'h3F, 1, 2, 3, 0);
    #2; check("illegal opcode", W'(a_illegal), W'(1));
    step(1'b1, OP_LW, 0, 7, 0, 0);
    settle_nops(3);

    // Counter saturation and $0 destinations
    step(1'b0, OP_J, 0, 0, 0, 0);
    step(1'b1, OP_J, 0, 0, 0, 0);
    step(1'b1, OP_LW, 0, 0, 0, 0);
    step(1'b1, OP_R, 0, 0, 0, 0);
    #2; check("dst zero no stall", W'(a_stall), W'(0));
    repeat (5) begin
      step(1'b1, OP_LW, 0, 1, 0, 0);
      step(1'b1, OP_R, 1, 0, 0, 0);
      step(1'b1, OP_R, 1, 0, 0, 0);
    end
    settle_nops(1);
    #2; check("count five", W'(a_cnt), W'(5)); check("count saturates", W'(b_cnt), W'(3));

    // Random instruction stream with occasional resets
    repeat (600) begin
      case ($urandom_range(0, 9))
        0, 1:    op = OP_R;
        2:       op = OP_ADDI;
        3, 4:    op = OP_LW;
        5:       op = OP_SW;
        6, 7:    op = OP_BEQ;
        8:       op = OP_J;
        default: op = 6'($urandom_range(0, 63));
      endcase
      step(($urandom_range(0, 49) != 0), op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4 && (exp_a_q.size() > 0 || exp_b_q.size() > 0); i++) begin
      @(negedge clk); #1;
    end
    if (exp_a_q.size() > 0 || exp_b_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_a_q.size() + exp_b_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
